// File: rtl/riffa_gowin_pkg.sv
// Shared types and helpers for the Gowin PCIe RX streaming path.
// The beat record holds the FIFO payload; its data field is sized for the widest supported bus.
package riffa_gowin_pkg;

  localparam int READY_LATENCY_MAX = 4;
  localparam int PCI_DATA_WIDTH_MAX = 256;

  typedef struct packed {
    logic sop;
    logic eop;
    logic empty;
  } beat_tag_t;

  typedef struct packed {
    logic [PCI_DATA_WIDTH_MAX-1:0] data;
    beat_tag_t                     tag;
  } beat_t;

  // Ceiling log2 that never returns 0, so a one-entry structure still gets a 1-bit index.
  function automatic int clog2s(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rx_st_ready_latency_buffer_if.sv
// Avalon-ST style beat stream: data plus packet sideband, valid forward, ready backward.
interface rx_st_ready_latency_buffer_if #(
  parameter int W = 256
);
  logic [W-1:0] data;
  logic         sop;
  logic         eop;
  logic         empty;
  logic         valid;
  logic         ready;

  modport master (output data, sop, eop, empty, valid, input  ready);
  modport slave  (input  data, sop, eop, empty, valid, output ready);
endinterface

// File: rtl/rx_st_fwft_fifo.sv
// First-word-fall-through beat FIFO: the head is read combinationally from storage.
// A write into a full FIFO is dropped unless a pop frees the slot in the same cycle.
module rx_st_fwft_fifo
  import riffa_gowin_pkg::*;
#(
  parameter int W     = 256,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wr_data,
  input  beat_tag_t                    wr_tag,
  input  logic                         pop,
  output logic [W-1:0]                 rd_data,
  output beat_tag_t                    rd_tag,
  output logic [clog2s(DEPTH+1)-1:0]   count_next,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = clog2s(DEPTH);
  localparam int CW = clog2s(DEPTH + 1);

  beat_t            mem [DEPTH];
  beat_t            head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    if (wr_en && !rd_en)      count_next = count + CW'(1);
    else if (!wr_en && rd_en) count_next = count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  // NOTE: storage has no reset; contents are only observable once count marks them valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{data: PCI_DATA_WIDTH_MAX'(wr_data), tag: wr_tag};
  end

  assign head    = mem[rd_ptr];
  assign rd_data = head.data[W-1:0];
  assign rd_tag  = head.tag;

endmodule

// File: rtl/rx_st_ready_latency_buffer.sv
// Absorbs beats the PCIe core keeps sending after ready drops (fixed ready latency),
// driving core ready from a credit count and presenting a zero-latency stream downstream.
module rx_st_ready_latency_buffer
  import riffa_gowin_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 256,
  parameter int C_READY_LATENCY  = 2,
  parameter int C_FIFO_DEPTH     = 8
) (
  input  logic                          CLK,
  input  logic                          RST_IN,
  rx_st_ready_latency_buffer_if.slave   rx_st,
  rx_st_ready_latency_buffer_if.master  rx,
  output logic                          OVERFLOW
);

  localparam int L  = C_READY_LATENCY;
  localparam int CW = clog2s(C_FIFO_DEPTH + 1);

  if (C_READY_LATENCY < 1 || C_READY_LATENCY > READY_LATENCY_MAX) begin : g_bad_latency
    $error("C_READY_LATENCY must be in 1..%0d", READY_LATENCY_MAX);
  end
  if ((C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0 || C_FIFO_DEPTH < C_READY_LATENCY + 2) begin : g_bad_depth
    $error("C_FIFO_DEPTH must be a power of two and at least C_READY_LATENCY+2");
  end
  if (C_PCI_DATA_WIDTH != 64 && C_PCI_DATA_WIDTH != 128 && C_PCI_DATA_WIDTH != 256) begin : g_bad_width
    $error("C_PCI_DATA_WIDTH must be 64, 128 or 256");
  end

  logic [L-1:0]    hist;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count_next;
  logic [2:0]      inflight;
  logic            ready_next;
  beat_tag_t       in_tag;
  beat_tag_t       head_tag;

  // A beat is only legal when ready was high exactly L cycles ago; anything else is ignored.
  assign push = rx_st.valid & hist[L-1];
  assign pop  = rx.valid & rx.ready;

  assign in_tag = '{sop: rx_st.sop, eop: rx_st.eop, empty: rx_st.empty};

  rx_st_fwft_fifo #(
    .W     (C_PCI_DATA_WIDTH),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RST_IN),
    .push       (push),
    .wr_data    (rx_st.data),
    .wr_tag     (in_tag),
    .pop        (pop),
    .rd_data    (rx.data),
    .rd_tag     (head_tag),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  assign rx.valid = ~empty;
  assign rx.sop   = head_tag.sop;
  assign rx.eop   = head_tag.eop;
  assign rx.empty = head_tag.empty;

  // Credits already granted but not yet landed: the younger history bits plus the current ready.
  always_comb begin
    inflight = 3'(rx_st.ready);
    for (int k = 0; k < L - 1; k++) inflight = inflight + 3'(hist[k]);
  end

  assign ready_next = (int'(count_next) + int'(inflight) + 1) <= C_FIFO_DEPTH;

  always_ff @(posedge CLK or posedge RST_IN) begin
    if (RST_IN) begin
      hist        <= '0;
      rx_st.ready <= 1'b0;
      OVERFLOW    <= 1'b0;
    end else begin
      hist        <= L'({hist, rx_st.ready});
      rx_st.ready <= ready_next;
      if (push && full && !pop) OVERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_st_ready_latency_buffer.sv
// Directed bench for the ready-latency buffer: a legal-core model feeds beats and a queue
// of expected beats checks what the downstream side pops.
module tb_rx_st_ready_latency_buffer;

  localparam int W = 256;
  localparam int L = 2;
  localparam int D = 8;

  typedef struct {
    logic [W+2:0] beat;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic overflow;

  rx_st_ready_latency_buffer_if #(.W(W)) core_if ();
  rx_st_ready_latency_buffer_if #(.W(W)) down_if ();

  rx_st_ready_latency_buffer #(
    .C_PCI_DATA_WIDTH (W),
    .C_READY_LATENCY  (L),
    .C_FIFO_DEPTH     (D)
  ) dut (
    .CLK      (clk),
    .RST_IN   (rst),
    .rx_st    (core_if),
    .rx       (down_if),
    .OVERFLOW (overflow)
  );

  always #5 clk = ~clk;

  int       total;
  int       bad;
  int       cyc;
  int       seq;
  int       core_stop;
  int       delivered;
  int       lat_bad;
  logic [L-1:0] bq;
  exp_t     q[$];

  task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W+2:0] make_beat(input int s);
    logic [31:0] word;
    word = 32'(s) ^ 32'h5A5A_0000;
    return {{8{word}}, (s % 4) == 0, (s % 4) == 3, word[1]};
  endfunction

  task automatic drive_beat(input logic [W+2:0] b);
    {core_if.data, core_if.sop, core_if.eop, core_if.empty} = b;
  endtask

  // Called at a negedge with this cycle's RX_READY already set; checks the pop,
  // runs the legal-core model, then advances to the next negedge.
  task automatic step();
    logic rdy;
    logic acc;
    exp_t e;
    if (down_if.valid && down_if.ready) begin
      if (q.size() == 0) begin
        check("rx_valid_unexpected", down_if.valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("rx_beat", {down_if.data, down_if.sop, down_if.eop, down_if.empty}, e.beat);
        delivered++;
        if (cyc - e.cyc != 1) lat_bad++;
      end
    end
    rdy = core_if.ready;
    acc = bq[L-1];
    if (seq < core_stop) begin
      core_if.valid = 1'b1;
      drive_beat(make_beat(seq));
      if (acc) begin
        q.push_back('{beat: make_beat(seq), cyc: cyc});
        seq++;
      end
    end else begin
      core_if.valid = 1'b0;
    end
    bq = {bq[L-2:0], rdy};
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int ready_low;
    int ready_high;
    int first_ready;
    int d0;

    total = 0; bad = 0; cyc = 0; seq = 0; core_stop = 0;
    delivered = 0; lat_bad = 0; bq = '0;
    core_if.valid = 1'b0;
    drive_beat('0);
    down_if.ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;

    // 1. reset then idle
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("rst_ready", core_if.ready, 1'b0);
      check("rst_valid", down_if.valid, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    check("ready_before_first_edge", core_if.ready, 1'b0);
    step();
    check("ready_first_edge", core_if.ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("idle_valid", down_if.valid, 1'b0);
      check("idle_overflow", overflow, 1'b0);
      step();
    end

    // 2. streaming 100 beats with downstream always ready
    down_if.ready = 1'b1;
    core_stop = 100;
    ready_low = 0;
    for (int i = 0; i < 300 && delivered < 100; i++) begin
      if (!core_if.ready) ready_low++;
      step();
    end
    check("stream_delivered", delivered, 100);
    check("stream_latency_errors", lat_bad, 0);
    check("stream_ready_low_cycles", ready_low, 0);
    check("stream_count_empty", dut.u_fifo.count, 0);

    // 3. downstream stall: ready stays high for 6 cycles, exactly 8 beats land
    down_if.ready = 1'b0;
    core_stop = seq + 1000;
    ready_high = 0;
    for (int i = 0; i < 20; i++) begin
      if (core_if.ready) ready_high++;
      step();
    end
    check("stall_ready_high_cycles", ready_high, 6);
    check("stall_expected_beats", q.size(), 8);
    check("stall_count", dut.u_fifo.count, 8);
    check("stall_ready", core_if.ready, 1'b0);
    check("stall_overflow", overflow, 1'b0);

    // 4. release: ready returns one cycle after the first pop, order preserved
    down_if.ready = 1'b1;
    first_ready = -1;
    for (int i = 0; i < 30; i++) begin
      if (core_if.ready && first_ready < 0) first_ready = i;
      step();
    end
    core_stop = seq;
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    step();
    check("release_first_ready", first_ready, 1);
    check("release_drained", q.size(), 0);
    check("release_count", dut.u_fifo.count, 0);

    // 5. forced protocol violation into a full FIFO
    down_if.ready = 1'b0;
    core_stop = seq + 1000;
    for (int i = 0; i < 15; i++) step();
    core_stop = seq;
    check("ovf_prefill_count", dut.u_fifo.count, 8);
    force dut.hist = '1;
    core_if.valid = 1'b1;
    drive_beat(make_beat(32'h0BAD));
    @(negedge clk);
    cyc++;
    release dut.hist;
    core_if.valid = 1'b0;
    check("ovf_flag", overflow, 1'b1);
    check("ovf_count", dut.u_fifo.count, 8);
    for (int i = 0; i < 3; i++) step();
    check("ovf_sticky", overflow, 1'b1);
    down_if.ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    step();
    check("ovf_drained", q.size(), 0);
    check("ovf_drained_valid", down_if.valid, 1'b0);
    check("ovf_sticky_after_drain", overflow, 1'b1);

    // 6. reset with a partial packet stored, then a clean packet
    seq = ((seq + 3) / 4) * 4;
    core_stop = seq + 3;
    down_if.ready = 1'b0;
    for (int i = 0; i < 20 && q.size() < 3; i++) step();
    step();
    check("partial_count", dut.u_fifo.count, 3);
    check("partial_head_sop", down_if.sop, 1'b1);
    core_if.valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", down_if.valid, 1'b0);
    check("midrst_count", dut.u_fifo.count, 0);
    check("midrst_overflow", overflow, 1'b0);
    q.delete();
    bq = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    seq = ((seq + 3) / 4) * 4;
    core_stop = seq + 4;
    down_if.ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 30 && (delivered - d0) < 4; i++) step();
    check("fresh_packet_beats", delivered - d0, 4);
    check("fresh_packet_leftover", q.size(), 0);
    check("fresh_overflow", overflow, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
